// File: rtl/key_cfg_pkg.sv
// key_cfg_pkg: key indices and FSM state encoding shared by key_cfg_ctrl, key_pend_arb and the bench.
package key_cfg_pkg;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_NEXT  = 2;
    localparam int KEY_APPLY = 3;
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_REQ  = 2'd2
    } state_t;
endpackage

// File: rtl/key_pend_arb.sv
// key_pend_arb: latches key pulses until serviced and picks one per cycle (APPLY > NEXT > UP/DOWN).
//  i_clk, i_rst_n : clock, async active-low reset
//  i_key_pulse    : 1-cycle key pulses, indexed by the KEY_* constants
//  i_en           : servicing allowed this cycle (controller idle)
//  o_grant        : one-hot serviced key, zero when nothing is serviced
//  o_cancel       : UP and DOWN were pending together and are both dropped
module key_pend_arb
    import key_cfg_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_key_pulse,
    input  logic       i_en,
    output logic [3:0] o_grant,
    output logic       o_cancel
);
    logic [3:0] r_pend;
    logic [3:0] w_clr;

    always_comb begin
        o_grant  = '0;
        o_cancel = 1'b0;
        if (i_en) begin
            if (r_pend[KEY_APPLY])
                o_grant[KEY_APPLY] = 1'b1;
            else if (r_pend[KEY_NEXT])
                o_grant[KEY_NEXT] = 1'b1;
            else if (r_pend[KEY_UP] && r_pend[KEY_DOWN])
                o_cancel = 1'b1;
            else if (r_pend[KEY_UP])
                o_grant[KEY_UP] = 1'b1;
            else if (r_pend[KEY_DOWN])
                o_grant[KEY_DOWN] = 1'b1;
        end
        w_clr = o_grant;
        w_clr[KEY_UP]   = o_grant[KEY_UP] | o_cancel;
        w_clr[KEY_DOWN] = o_grant[KEY_DOWN] | o_cancel;
    end

    // A pulse landing in the same cycle its bit is cleared re-sets it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pend <= '0;
        else
            r_pend <= (r_pend & ~w_clr) | i_key_pulse;
    end
endmodule

// File: rtl/key_cfg_ctrl.sv
// key_cfg_ctrl: turns key pulses into field edits and pushes them to the datapath over valid/ready with timeout.
//  i_clk, i_rst_n : clock, async active-low reset
//  i_key_pulse    : [0]=UP [1]=DOWN [2]=NEXT [3]=APPLY, 1-cycle pulses
//  i_cfg_ready    : datapath accepts o_cfg_data
//  o_cfg_valid    : transfer request; o_cfg_data frozen while high
//  o_cfg_data     : field i at [i*FIELD_W +: FIELD_W]
//  o_field_sel    : field being edited
//  o_busy         : high in INIT or REQ
//  o_cfg_err      : sticky, last transfer timed out
//  Macro KEY_CFG_CTRL_WRAP_EN: fields wrap at their bounds instead of saturating.
module key_cfg_ctrl
    import key_cfg_pkg::*;
#(
    parameter int NUM_FIELDS  = 4,
    parameter int FIELD_W     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [3:0]                    i_key_pulse,
    input  logic                          i_cfg_ready,
    output logic                          o_cfg_valid,
    output logic [NUM_FIELDS*FIELD_W-1:0] o_cfg_data,
    output logic [$clog2(NUM_FIELDS)-1:0] o_field_sel,
    output logic                          o_busy,
    output logic                          o_cfg_err
);
    localparam int SEL_W  = $clog2(NUM_FIELDS);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int DATA_W = NUM_FIELDS * FIELD_W;
    localparam logic [FIELD_W-1:0] FLD_MAX = '1;

    state_t             r_state, w_state_nxt;
    logic               r_valid, w_valid_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic [DATA_W-1:0]  r_shadow, w_shadow_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt, w_sel_inc;
    logic               r_err, w_err_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic [FIELD_W-1:0] w_fld, w_fld_up, w_fld_dn;
    logic [3:0]         w_grant;
    logic               w_cancel;

    key_pend_arb u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_key_pulse (i_key_pulse),
        .i_en        (r_state == ST_IDLE),
        .o_grant     (w_grant),
        .o_cancel    (w_cancel)
    );

    assign w_fld     = r_shadow[int'(r_sel)*FIELD_W +: FIELD_W];
    assign w_sel_inc = (r_sel == SEL_W'(NUM_FIELDS - 1)) ? '0 : r_sel + SEL_W'(1);
`ifdef KEY_CFG_CTRL_WRAP_EN
    assign w_fld_up  = w_fld + FIELD_W'(1);
    assign w_fld_dn  = w_fld - FIELD_W'(1);
`else
    assign w_fld_up  = (w_fld == FLD_MAX) ? w_fld : w_fld + FIELD_W'(1);
    assign w_fld_dn  = (w_fld == '0) ? w_fld : w_fld - FIELD_W'(1);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_data_nxt   = r_data;
        w_shadow_nxt = r_shadow;
        w_sel_nxt    = r_sel;
        w_err_nxt    = r_err;
        w_timer_nxt  = r_timer;
        case (r_state)
            ST_INIT: begin
                w_data_nxt  = r_shadow;
                w_valid_nxt = 1'b1;
                w_timer_nxt = '0;
                w_state_nxt = ST_REQ;
            end
            ST_IDLE: begin
                if (w_grant[KEY_APPLY]) begin
                    w_data_nxt  = r_shadow;
                    w_valid_nxt = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_REQ;
                end else if (w_grant[KEY_NEXT])
                    w_sel_nxt = w_sel_inc;
                else if (!w_cancel && w_grant[KEY_UP])
                    w_shadow_nxt[int'(r_sel)*FIELD_W +: FIELD_W] = w_fld_up;
                else if (!w_cancel && w_grant[KEY_DOWN])
                    w_shadow_nxt[int'(r_sel)*FIELD_W +: FIELD_W] = w_fld_dn;
            end
            ST_REQ: begin
                // A ready arriving on the timeout cycle still completes the transfer.
                if (i_cfg_ready) begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    w_valid_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else
                    w_timer_nxt = r_timer + TMR_W'(1);
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_INIT;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_shadow <= '0;
            r_sel    <= '0;
            r_err    <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
            r_shadow <= w_shadow_nxt;
            r_sel    <= w_sel_nxt;
            r_err    <= w_err_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    assign o_cfg_valid = r_valid;
    assign o_cfg_data  = r_data;
    assign o_field_sel = r_sel;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_cfg_err   = r_err;
endmodule
